ticket_change_dispenser: RTL and testbench
==========================================

// Module: ticket_change_dispenser
// PURPOSE
//   Output end of the ticket shop: consumes the completed-sale result (ticket count + change amount)
//   and drives the physical issue mechanisms. Issues tickets one per handshake, then pays change
//   coin by coin using greedy TWD denominations (50/10/5/1). Sits between the sale FSM and the
//   ticket printer / coin hopper; stalls on either mechanism without losing state.
// PARAMETERS
//   AMT_W   32  width of change amount and coin counter
//   CNT_W   32  width of ticket count
// PORTS
//   clock         in   1      single clock; all state changes on posedge
//   reset         in   1      synchronous, active-high reset
//   req_valid     in   1      sale result valid (in_cash/in_num sampled when req_valid&&req_ready)
//   req_ready     out  1      high only in IDLE
//   in_cash       in   AMT_W  change to pay, TWD
//   in_num        in   CNT_W  tickets to issue
//   ticket_valid  out  1      ticket issue request to printer
//   ticket_ready  in   1      printer accepts one ticket this cycle
//   coin_valid    out  1      coin issue request to hopper
//   coin_value    out  6      denomination of offered coin: 50, 10, 5 or 1 (0 when !coin_valid)
//   coin_ready    in   1      hopper accepts the offered coin this cycle
//   busy          out  1      high in TICKET, COIN, DONE
//   done          out  1      one-cycle pulse: transaction finished
//   coins_paid    out  AMT_W  coins issued in current/last transaction; holds until next accept
// BEHAVIOUR
//   Reset (sync): state=IDLE; req_ready=1; ticket_valid=coin_valid=busy=done=0; coin_value=0;
//     coins_paid=0; internal remaining-cash and remaining-ticket registers cleared.
//   Outputs are decoded from registered state/counters only (Moore); no input->output comb path
//     except none: valid/value never depend on ready.
//   States / transitions (evaluated at posedge, reset has priority):
//     IDLE  : req_ready=1. On req_valid: latch in_cash->rem_cash, in_num->rem_num, coins_paid<=0;
//             next = TICKET if in_num!=0, else COIN if in_cash!=0, else DONE. req_valid=0: stay.
//     TICKET: ticket_valid=1. On ticket_ready: rem_num--; if rem_num==1 -> (rem_cash!=0 ? COIN:DONE).
//             ticket_ready=0: hold, no change.
//     COIN  : coin_valid=1; coin_value = 50 if rem_cash>=50, else 10 if >=10, else 5 if >=5, else 1.
//             On coin_ready: rem_cash -= coin_value; coins_paid++; if rem_cash==coin_value -> DONE.
//             coin_ready=0: coin_value held stable, no change.
//     DONE  : done=1 for exactly one cycle; next = IDLE.
//   Latency (readies held high): request accepted at edge 0 -> ticket_valid cycles 1..N,
//     coin_valid cycles N+1..N+C, done in cycle N+C+1, req_ready again cycle N+C+2.
//   req_valid outside IDLE is ignored (no latch, no effect); the sale FSM must wait for req_ready.
//   ticket_ready during COIN/IDLE and coin_ready during TICKET/IDLE are ignored.
//   Tickets always complete before any coin is offered; never both valids high together.
//   Arithmetic: rem_cash subtraction unsigned, never underflows (value <= rem_cash by construction);
//     coins_paid wraps modulo 2^AMT_W (not reachable in practice, no saturation).
//   Reset mid-transaction: abandons remaining tickets/coins, returns to IDLE next cycle, no done.
// TESTING
//   1. in_num=2,in_cash=67, readies=1 -> ticket_valid cycles 1-2; coins 50,10,5,1,1 cycles 3-7;
//      done cycle 8; coins_paid=5; req_ready=1 cycle 9.
//   2. in_num=0,in_cash=0 -> no ticket/coin beats; done in cycle 1; coins_paid=0.
//   3. in_num=0,in_cash=23, coin_ready low 3 cycles at first coin -> coin_value=10 held stable
//      for 3 cycles; sequence 10,10,1,1,1; coins_paid=5.
//   4. in_num=3, ticket_ready toggled 1,0,1,0,1 -> exactly 3 accepted tickets, then done (cash=0).
//   5. reset asserted during COIN with rem_cash=40 -> next cycle all valids 0, req_ready=1,
//      coins_paid=0, no done pulse; a new request then runs normally.
//   6. req_valid pulsed (in_num=9) while busy -> ignored; original transaction counts unchanged.

Source files
------------

// File: rtl/ticket_change_dispenser.sv
// Output stage of the ticket shop: issues the sold tickets one per printer handshake,
// then pays the change coin by coin with greedy TWD denominations (50/10/5/1).
module ticket_change_dispenser #(
    parameter int AMT_W = 32,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] in_cash,
    input  logic [CNT_W-1:0] in_num,
    output logic             ticket_valid,
    input  logic             ticket_ready,
    output logic             coin_valid,
    output logic [5:0]       coin_value,
    input  logic             coin_ready,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] coins_paid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TICKET = 2'd1,
        ST_COIN   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic req_ready;
        logic ticket_valid;
        logic coin_valid;
        logic busy;
        logic done;
    } flags_t;

    state_t             state_r;
    flags_t             flags_r;
    logic [AMT_W-1:0]   rem_cash_r;
    logic [CNT_W-1:0]   rem_num_r;
    logic [AMT_W-1:0]   coins_paid_r;
    logic [5:0]         coin_value_r;
    logic [AMT_W-1:0]   coin_ext_s;

    // Largest denomination that does not exceed the remaining amount.
    function automatic logic [5:0] greedy_coin(input logic [AMT_W-1:0] amount);
        if (amount >= AMT_W'(32'd50)) begin
            return 6'd50;
        end else if (amount >= AMT_W'(32'd10)) begin
            return 6'd10;
        end else if (amount >= AMT_W'(32'd5)) begin
            return 6'd5;
        end else begin
            return 6'd1;
        end
    endfunction

    // Output flags are a pure function of the state being entered, so they can be registered.
    function automatic flags_t flags_for(input state_t s);
        flags_t f;
        f = '0;
        case (s)
            ST_IDLE:   f.req_ready = 1'b1;
            ST_TICKET: begin f.ticket_valid = 1'b1; f.busy = 1'b1; end
            ST_COIN:   begin f.coin_valid   = 1'b1; f.busy = 1'b1; end
            ST_DONE:   begin f.done         = 1'b1; f.busy = 1'b1; end
            default:   f.req_ready = 1'b1;
        endcase
        return f;
    endfunction

    // Offered coin widened to the cash width for subtraction and the last-coin compare.
    assign coin_ext_s = AMT_W'(coin_value_r);

    // Transaction FSM; outputs are registered together with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            flags_r      <= flags_for(ST_IDLE);
            rem_cash_r   <= '0;
            rem_num_r    <= '0;
            coins_paid_r <= '0;
            coin_value_r <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        rem_cash_r   <= in_cash;
                        rem_num_r    <= in_num;
                        coins_paid_r <= '0;
                        if (in_num != '0) begin
                            state_r      <= ST_TICKET;
                            flags_r      <= flags_for(ST_TICKET);
                            coin_value_r <= 6'd0;
                        end else if (in_cash != '0) begin
                            state_r      <= ST_COIN;
                            flags_r      <= flags_for(ST_COIN);
                            coin_value_r <= greedy_coin(in_cash);
                        end else begin
                            state_r      <= ST_DONE;
                            flags_r      <= flags_for(ST_DONE);
                            coin_value_r <= 6'd0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_TICKET: begin
                    if (ticket_ready) begin
                        rem_num_r <= rem_num_r - CNT_W'(1'b1);
                        if (rem_num_r == CNT_W'(1'b1)) begin
                            if (rem_cash_r != '0) begin
                                state_r      <= ST_COIN;
                                flags_r      <= flags_for(ST_COIN);
                                coin_value_r <= greedy_coin(rem_cash_r);
                            end else begin
                                state_r      <= ST_DONE;
                                flags_r      <= flags_for(ST_DONE);
                                coin_value_r <= 6'd0;
                            end
                        end else begin
                            state_r <= ST_TICKET;
                        end
                    end else begin
                        state_r <= ST_TICKET;
                    end
                end
                ST_COIN: begin
                    // coin_value_r always equals greedy_coin(rem_cash_r) while in this state.
                    if (coin_ready) begin
                        rem_cash_r   <= rem_cash_r - coin_ext_s;
                        coins_paid_r <= coins_paid_r + AMT_W'(1'b1);
                        if (rem_cash_r == coin_ext_s) begin
                            state_r      <= ST_DONE;
                            flags_r      <= flags_for(ST_DONE);
                            coin_value_r <= 6'd0;
                        end else begin
                            coin_value_r <= greedy_coin(rem_cash_r - coin_ext_s);
                        end
                    end else begin
                        state_r <= ST_COIN;
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    flags_r      <= flags_for(ST_IDLE);
                    coin_value_r <= 6'd0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    flags_r      <= flags_for(ST_IDLE);
                    coin_value_r <= 6'd0;
                end
            endcase
        end
    end

    assign req_ready    = flags_r.req_ready;
    assign ticket_valid = flags_r.ticket_valid;
    assign coin_valid   = flags_r.coin_valid;
    assign busy         = flags_r.busy;
    assign done         = flags_r.done;
    assign coin_value   = coin_value_r;
    assign coins_paid   = coins_paid_r;

endmodule

// File: tb/tb_ticket_change_dispenser.sv
// Scoreboard bench for ticket_change_dispenser: directed scenarios plus randomized
// transactions checked against a denomination-count reference model.
module tb_ticket_change_dispenser;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] in_cash;
    logic [31:0] in_num;
    logic        ticket_valid;
    logic        ticket_ready;
    logic        coin_valid;
    logic [5:0]  coin_value;
    logic        coin_ready;
    logic        busy;
    logic        done;
    logic [31:0] coins_paid;

    ticket_change_dispenser #(.AMT_W(32), .CNT_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .in_cash      (in_cash),
        .in_num       (in_num),
        .ticket_valid (ticket_valid),
        .ticket_ready (ticket_ready),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .coin_ready   (coin_ready),
        .busy         (busy),
        .done         (done),
        .coins_paid   (coins_paid)
    );

    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ready_mode = 2;  // 1: random readies each cycle, otherwise driven by the stimulus
    int exp_num_q[$];
    int exp_paid_q[$];
    int exp_coin_q[$];
    int tick_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [5:0] prev_val   = 6'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: greedy change expressed as per-denomination counts.
    function automatic void model_push(input int num, input int cash);
        int n50, n10, n5, n1;
        n50 = cash / 50;
        n10 = (cash % 50) / 10;
        n5  = (cash % 10) / 5;
        n1  = cash % 5;
        repeat (n50) exp_coin_q.push_back(50);
        repeat (n10) exp_coin_q.push_back(10);
        repeat (n5)  exp_coin_q.push_back(5);
        repeat (n1)  exp_coin_q.push_back(1);
        exp_num_q.push_back(num);
        exp_paid_q.push_back(n50 + n10 + n5 + n1);
    endfunction

    // Monitor: compares every accepted coin and every completed transaction.
    always @(negedge clock) begin
        if (reset) begin
            tick_cnt   = 0;
            prev_stall = 1'b0;
        end else begin
            if (ticket_valid || coin_valid)
                check("valid_exclusive", {31'd0, ticket_valid && coin_valid}, 32'd0);
            if (ticket_valid && ticket_ready) tick_cnt++;
            if (coin_valid) begin
                if (prev_stall) check("coin_stable", {26'd0, coin_value}, {26'd0, prev_val});
                if (coin_ready) begin
                    if (exp_coin_q.size() == 0) check("coin_unexpected", {26'd0, coin_value}, 32'd0);
                    else check("coin_value", {26'd0, coin_value}, exp_coin_q.pop_front());
                end
            end
            prev_stall = coin_valid && !coin_ready;
            prev_val   = coin_value;
            if (done) begin
                if (exp_num_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    check("tickets_issued", tick_cnt, exp_num_q.pop_front());
                    check("coins_paid", coins_paid, exp_paid_q.pop_front());
                    check("coins_left", exp_coin_q.size(), 32'd0);
                    check("coin_value_idle", {26'd0, coin_value}, 32'd0);
                end
                tick_cnt = 0;
            end
        end
    end

    // Random ready driver.
    always begin
        @(posedge clock);
        #1;
        if (ready_mode == 1) begin
            ticket_ready = ($urandom_range(0, 3) != 0);
            coin_ready   = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input int num, input int cash);
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        in_num    = num;
        in_cash   = cash;
        model_push(num, cash);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (req_ready && exp_num_q.size() == 0) break;
        end
        if (k == 3000) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] tv, cv, dn, rr;
        reset = 1'b1; req_valid = 1'b0; in_cash = 32'd0; in_num = 32'd0;
        ticket_ready = 1'b0; coin_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valids", {30'd0, ticket_valid, coin_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_coin_value", {26'd0, coin_value}, 32'd0);
        check("rst_coins_paid", coins_paid, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // 1: latency with readies held high
        ticket_ready = 1'b1; coin_ready = 1'b1;
        issue(2, 67);
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            tv[c] = ticket_valid; cv[c] = coin_valid; dn[c] = done; rr[c] = req_ready;
        end
        check("t1_ticket_cycles", {23'd0, tv}, {23'd0, 9'b000000011});
        check("t1_coin_cycles", {23'd0, cv}, {23'd0, 9'b001111100});
        check("t1_done_cycle", {23'd0, dn}, {23'd0, 9'b010000000});
        check("t1_ready_cycle", {23'd0, rr}, {23'd0, 9'b100000000});
        check("t1_coins_paid", coins_paid, 32'd5);
        wait_idle();

        // 2: empty transaction
        issue(0, 0);
        @(negedge clock);
        check("t2_done_c1", {31'd0, done}, 32'd1);
        check("t2_no_valid", {30'd0, ticket_valid, coin_valid}, 32'd0);
        @(negedge clock);
        check("t2_ready_c2", {31'd0, req_ready}, 32'd1);
        wait_idle();

        // 3: hopper stall on the first coin
        coin_ready = 1'b0;
        issue(0, 23);
        repeat (3) begin
            @(negedge clock);
            check("t3_hold_value", {26'd0, coin_value}, 32'd10);
        end
        @(posedge clock);
        #1 coin_ready = 1'b1;
        wait_idle();
        check("t3_coins_paid", coins_paid, 32'd5);

        // 4: printer ready toggling 1,0,1,0,1
        ticket_ready = 1'b1;
        issue(3, 0);
        for (int i = 1; i < 5; i++) begin
            @(posedge clock);
            #1 ticket_ready = (i % 2 == 0);
        end
        wait_idle();
        ticket_ready = 1'b1;

        // 5: reset during COIN with 40 left
        issue(0, 90);
        @(negedge clock);
        @(negedge clock);
        check("t5_pre_reset_coin", {26'd0, coin_value}, 32'd10);
        #1 reset = 1'b1;
        exp_num_q.delete(); exp_paid_q.delete(); exp_coin_q.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("t5_valids", {30'd0, ticket_valid, coin_valid}, 32'd0);
        check("t5_req_ready", {31'd0, req_ready}, 32'd1);
        check("t5_coins_paid", coins_paid, 32'd0);
        repeat (3) begin
            check("t5_no_done", {31'd0, done}, 32'd0);
            @(negedge clock);
        end
        issue(1, 7);
        wait_idle();

        // 6: request while busy is ignored
        ticket_ready = 1'b0;
        issue(2, 6);
        @(negedge clock);
        check("t6_not_ready", {31'd0, req_ready}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd1);
        @(posedge clock);
        #1; req_valid = 1'b1; in_num = 32'd9; in_cash = 32'd99;
        @(posedge clock);
        #1; req_valid = 1'b0; ticket_ready = 1'b1;
        wait_idle();

        // Randomized transactions with random backpressure
        ready_mode = 1;
        repeat (30) begin
            issue(int'($urandom_range(0, 4)), int'($urandom_range(0, 130)));
            wait_idle();
        end
        ready_mode = 2;
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
